// File: rtl/gray_ptr_pkg.sv
// Shared constants and width-generic Gray/binary conversion helpers for the
// Gray pointer synchroniser.
package gray_ptr_pkg;

  localparam int MIN_STAGES    = 2;
  localparam int MAX_STAGES    = 4;
  localparam int MAX_PTR_WIDTH = 32;
  // Arming counter must reach MAX_STAGES+1.
  localparam int ARM_CNT_WIDTH = $clog2(MAX_STAGES + 2);

  // Narrower pointers are zero-extended by the caller; leading zeros leave the
  // low bits of either conversion unchanged.
  function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] g);
    logic [MAX_PTR_WIDTH-1:0] b;
    b[MAX_PTR_WIDTH-1] = g[MAX_PTR_WIDTH-1];
    for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_ptr_sync_if.sv
// Pointer bus between the async-FIFO source logic (master) and the
// destination-domain Gray pointer synchroniser (slave).
interface gray_ptr_sync_if #(
  parameter int PTR_WIDTH = 8
);

  logic [PTR_WIDTH-1:0] gray_in;
  logic                 err_clr;
  logic [PTR_WIDTH-1:0] gray_out;
  logic [PTR_WIDTH-1:0] bin_out;
  logic                 ptr_adv;
  logic [PTR_WIDTH-1:0] adv_cnt;
  logic                 err_step;

  modport master (
    output gray_in, err_clr,
    input  gray_out, bin_out, ptr_adv, adv_cnt, err_step
  );

  modport slave (
    input  gray_in, err_clr,
    output gray_out, bin_out, ptr_adv, adv_cnt, err_step
  );

endinterface

// File: rtl/gray_ptr_sync_stages.sv
// Plain N-flop synchroniser chain; the first flop samples an asynchronous bus,
// so nothing may sit between stages.
module sync_stages #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] s;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; the whole array is reset because these
  // are discrete flops, not a RAM, and must start from a known Gray 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= '0;
    end else begin
      s <= {s[STAGES-2:0], d};
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer CDC synchroniser with registered Gray-to-binary conversion and
// advance reporting. Define GRAY_SYNC_CHECK_EN to add the sticky step checker.
module gray_ptr_sync
  import gray_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int STAGES     = 2,
  parameter int MAX_STEP   = 2 ** ADDR_WIDTH
) (
  input logic            clk,
  input logic            rst,
  gray_ptr_sync_if.slave bus
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("gray_ptr_sync: STAGES must be in 2..4");
  end

  logic [PTR_WIDTH-1:0] gray_q;
  logic [PTR_WIDTH-1:0] nxt_bin;
  logic [PTR_WIDTH-1:0] delta;
  logic [PTR_WIDTH-1:0] bin_q;
  logic [PTR_WIDTH-1:0] adv_cnt_q;
  logic                 ptr_adv_q;

  sync_stages #(
    .WIDTH (PTR_WIDTH),
    .STAGES(STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (bus.gray_in),
    .q  (gray_q)
  );

  assign nxt_bin = PTR_WIDTH'(gray2bin(MAX_PTR_WIDTH'(gray_q)));
  // Modular subtraction makes the wrap from all-ones to zero a step of one.
  assign delta   = nxt_bin - bin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q     <= '0;
      ptr_adv_q <= 1'b0;
      adv_cnt_q <= '0;
    end else begin
      bin_q     <= nxt_bin;
      ptr_adv_q <= (delta != '0);
      adv_cnt_q <= delta;
    end
  end

`ifdef GRAY_SYNC_CHECK_EN
  localparam logic [PTR_WIDTH:0]     MAX_STEP_W = (PTR_WIDTH + 1)'(MAX_STEP);
  localparam logic [ARM_CNT_WIDTH-1:0] ARM_TERM = ARM_CNT_WIDTH'(STAGES + 1);

  logic [ARM_CNT_WIDTH-1:0] arm_cnt;
  logic                     armed;
  logic                     err_q;

  // The chain still holds reset zeros while filling; the first real sample can
  // legitimately look like a huge jump from 0, so the check waits it out.
  assign armed = (arm_cnt == ARM_TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (!armed) begin
        arm_cnt <= arm_cnt + 1'b1;
      end
      if (armed && ({1'b0, delta} > MAX_STEP_W)) begin
        err_q <= 1'b1;
      end else if (bus.err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.err_step = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_step   = 1'b0;
`endif

  assign bus.gray_out = gray_q;
  assign bus.bin_out  = bin_q;
  assign bus.ptr_adv  = ptr_adv_q;
  assign bus.adv_cnt  = adv_cnt_q;

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: a STAGES=2 and a STAGES=4 instance share
// one stimulus stream; err_step expectations follow GRAY_SYNC_CHECK_EN.
module tb_gray_ptr_sync;

`ifdef GRAY_SYNC_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] g   = 8'h00;
  logic       clr = 1'b0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  gray_ptr_sync_if #(.PTR_WIDTH(8)) if2 ();
  gray_ptr_sync_if #(.PTR_WIDTH(8)) if4 ();

  assign if2.gray_in = g;
  assign if2.err_clr = clr;
  assign if4.gray_in = g;
  assign if4.err_clr = clr;

  gray_ptr_sync #(.ADDR_WIDTH(7), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  gray_ptr_sync #(.ADDR_WIDTH(7), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past n rising edges, then settle 1 time unit away from the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero2(input string tag);
    check({tag, "_gray2"}, 32'(if2.gray_out), 0);
    check({tag, "_bin2"},  32'(if2.bin_out), 0);
    check({tag, "_adv2"},  32'(if2.ptr_adv), 0);
    check({tag, "_cnt2"},  32'(if2.adv_cnt), 0);
    check({tag, "_err2"},  32'(if2.err_step), 0);
    check({tag, "_bin4"},  32'(if4.bin_out), 0);
  endtask

  initial begin
    // Reset held while gray_in toggles.
    g = 8'h55; tick(1); check_zero2("rst_a");
    g = 8'hAA; tick(1); check_zero2("rst_b");
    g = 8'h55; tick(1); check_zero2("rst_c");

    // Release with a zero pointer; long enough to arm both instances.
    g = 8'h00; rst = 1'b0;
    tick(6);
    check("post_rst_adv2", 32'(if2.ptr_adv), 0);
    check("post_rst_err2", 32'(if2.err_step), 0);
    check("post_rst_adv4", 32'(if4.ptr_adv), 0);

    // Latency: gray 0 -> 01.
    g = 8'h01;
    tick(1); check("lat_e1_gray2", 32'(if2.gray_out), 0);
    tick(1); check("lat_e2_gray2", 32'(if2.gray_out), 32'h01);
             check("lat_e2_bin2",  32'(if2.bin_out), 0);
    tick(1); check("lat_e3_bin2",  32'(if2.bin_out), 1);
             check("lat_e3_adv2",  32'(if2.ptr_adv), 1);
             check("lat_e3_cnt2",  32'(if2.adv_cnt), 1);
             check("lat_e3_gray4", 32'(if4.gray_out), 0);
    tick(1); check("lat_e4_adv2",  32'(if2.ptr_adv), 0);
             check("lat_e4_cnt2",  32'(if2.adv_cnt), 0);
             check("lat_e4_gray4", 32'(if4.gray_out), 32'h01);
             check("lat_e4_bin4",  32'(if4.bin_out), 0);
    tick(1); check("lat_e5_bin4",  32'(if4.bin_out), 1);
             check("lat_e5_adv4",  32'(if4.ptr_adv), 1);
             check("lat_e5_cnt4",  32'(if4.adv_cnt), 1);
    tick(1); check("lat_e6_adv4",  32'(if4.ptr_adv), 0);

    // Walk to 255 in legal steps (1->128->255), then wrap to 0.
    g = 8'hC0; tick(6); check("walk_bin128", 32'(if2.bin_out), 128);
    g = 8'h80; tick(6); check("walk_bin255", 32'(if2.bin_out), 255);
                        check("walk_err2",   32'(if2.err_step), 0);
    g = 8'h00;
    tick(3); check("wrap_bin2", 32'(if2.bin_out), 0);
             check("wrap_adv2", 32'(if2.ptr_adv), 1);
             check("wrap_cnt2", 32'(if2.adv_cnt), 1);
    tick(2); check("wrap_cnt4", 32'(if4.adv_cnt), 1);
             check("wrap_err2", 32'(if2.err_step), 0);
             check("wrap_err4", 32'(if4.err_step), 0);

    // Step check: 0->10, 10->14 (4), 14->143 (129 > 128).
    g = 8'h0F; tick(6); check("step_bin10", 32'(if2.bin_out), 10);
    g = 8'h09;
    tick(3); check("step4_cnt2", 32'(if2.adv_cnt), 4);
             check("step4_err2", 32'(if2.err_step), 0);
    tick(3);
    g = 8'hC8;
    tick(3); check("step129_cnt2", 32'(if2.adv_cnt), 129);
             check("step129_err2", 32'(if2.err_step), 32'(CHK));
    tick(2); check("step129_cnt4", 32'(if4.adv_cnt), 129);
             check("step129_err4", 32'(if4.err_step), 32'(CHK));
    tick(2); check("sticky_err2",  32'(if2.err_step), 32'(CHK));
             check("sticky_err4",  32'(if4.err_step), 32'(CHK));
    clr = 1'b1;
    tick(1); check("clr_err2", 32'(if2.err_step), 0);
             check("clr_err4", 32'(if4.err_step), 0);
    clr = 1'b0;

    // 143 -> 16 (delta 129) with err_clr on the STAGES=2 update edge.
    g = 8'h18;
    tick(2); clr = 1'b1;
    tick(1); check("setwins_cnt2", 32'(if2.adv_cnt), 129);
             check("setwins_err2", 32'(if2.err_step), 32'(CHK));
    clr = 1'b0;
    tick(2); check("setwins_err4", 32'(if4.err_step), 32'(CHK));

    // Mid-run asynchronous reset from bin 37.
    g = 8'h37; tick(6);
    check("mid_bin2", 32'(if2.bin_out), 37);
    check("mid_bin4", 32'(if4.bin_out), 37);
    rst = 1'b1;
    #2;
    check_zero2("async_rst");
    g = 8'hAC;
    tick(1); check("rst_hold_gray2", 32'(if2.gray_out), 0);
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      check($sformatf("fill_err2_%0d", i), 32'(if2.err_step), 0);
      check($sformatf("fill_err4_%0d", i), 32'(if4.err_step), 0);
      if (i == 2) check("fill_bin2_e2", 32'(if2.bin_out), 0);
      if (i == 3) begin
        check("fill_bin2_e3", 32'(if2.bin_out), 200);
        check("fill_cnt2_e3", 32'(if2.adv_cnt), 200);
      end
      if (i == 4) check("fill_bin4_e4", 32'(if4.bin_out), 0);
      if (i == 5) check("fill_bin4_e5", 32'(if4.bin_out), 200);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gray_ptr_sync.md
# gray_ptr_sync

Parametrised N-stage clock-domain-crossing synchroniser for Gray-coded FIFO pointers, with in-domain Gray-to-binary conversion, advance detection and optional pointer-step checking. One instance per direction in the async FIFO: write pointer into the read domain, read pointer into the write domain. Replaces the fixed two-flop pointer synchroniser with configurable depth and pointer-aware outputs for full/empty and occupancy logic.

## Interface
- ADDR_WIDTH, 7, FIFO address width; pointer width PTR_WIDTH = ADDR_WIDTH+1 (derived localparam, includes wrap bit)
- STAGES, 2, synchroniser flop count; legal 2..4, elaboration error otherwise
- MAX_STEP, 2**ADDR_WIDTH, largest legal binary advance between consecutive synchronised samples
- clk  in  1  destination-domain clock
- rst  in  1  asynchronous, active-high reset
- gray_in  in  PTR_WIDTH  Gray pointer from source domain (asynchronous to clk)
- err_clr  in  1  synchronous clear of err_step
- gray_out  out  PTR_WIDTH  synchronised Gray pointer
- bin_out  out  PTR_WIDTH  binary equivalent of synchronised pointer, registered
- ptr_adv  out  1  one-cycle pulse: bin_out changed this cycle
- adv_cnt  out  PTR_WIDTH  modular advance (new bin_out − previous bin_out) in the ptr_adv cycle, else 0
- err_step  out  1  sticky: an advance exceeded MAX_STEP

## Operation
- Sync chain: gray_in → s[0] → … → s[STAGES-1]; gray_out = s[STAGES-1]. No logic between stages.
- Convert stage: nxt_bin = gray2bin(gray_out); delta = nxt_bin − bin_out mod 2**PTR_WIDTH.
- Each edge: bin_out ← nxt_bin; ptr_adv ← (delta != 0); adv_cnt ← delta.
- Wrap-around handled by modular subtraction: 255 → 0 (PTR_WIDTH=8) gives adv_cnt=1.
- Step check: on any edge where delta > MAX_STEP (unsigned) and check armed, err_step ← 1. Covers backward moves (appear as large modular deltas) and corrupted samples.
- err_step sticky until err_clr; same-edge set and err_clr → set wins.
- Arming: small counter cleared by reset counts STAGES+1 edges after rst deasserts; check disarmed until terminal count, then armed until next reset.
- All flops reset to 0 asynchronously; gray 0 ≡ binary 0, so first post-reset sample compares against 0.

## Timing
- Reset values: gray_out 0, bin_out 0, ptr_adv 0, adv_cnt 0, err_step 0; arming counter 0.
- rst assertion mid-operation clears all outputs immediately (no clock needed); gray_in ignored while rst high.
- Latency gray_in → gray_out: STAGES edges (gray_in stable through sample).
- Latency gray_in → bin_out/ptr_adv/adv_cnt/err_step: STAGES+1 edges, all four update on same edge.
- ptr_adv high exactly one cycle per change; back-to-back changes give consecutive pulses with individual adv_cnt values.
- Multiple source increments between samples are legal; adv_cnt reports total advance.

## Configuration
- GRAY_SYNC_CHECK_EN defined: MAX_STEP comparator, arming counter and err_step flop present; err_clr honoured.
- Undefined: err_step tied 0, err_clr unused, comparator and counter absent; all other behaviour identical.

## Structure
- Package gray_ptr_pkg: functions gray2bin and bin2gray (width-generic), localparams MIN_STAGES=2, MAX_STAGES=4.
- Sub-module sync_stages (WIDTH, STAGES): plain flop chain with async active-high reset, instantiated once; conversion, advance and check logic in gray_ptr_sync.

## Test plan
- Reset: rst=1, gray_in=8'h55 toggling → all outputs 0 throughout; deassert → no ptr_adv, err_step 0.
- Latency STAGES=2: gray_in 0→8'h01 → gray_out=8'h01 after 2 edges; bin_out=1, ptr_adv=1, adv_cnt=1 after 3 edges; ptr_adv=0 next cycle.
- Wrap: bin 255 (gray 8'h80) → bin 0 (gray 8'h00) → adv_cnt=1, err_step 0.
- Step check (macro on, MAX_STEP=128): bin 10→14 → adv_cnt=4, err_step 0; 14→143 → adv_cnt=129, err_step=1 sticky; err_clr=1 → 0 next edge; err_clr with new violation same edge → stays 1.
- STAGES=4: single change → gray_out after 4 edges, bin_out/ptr_adv after 5; macro off run of previous case → err_step stays 0.
- Mid-run reset: bin_out=37, assert rst asynchronously → outputs 0 before next edge; release with gray_in=bin2gray(200) → no err_step during fill window, bin_out=200 after STAGES+1 edges.
